// File: rtl/jt053260_pkg.sv
// Shared types and constants for the K053260 sample-ROM scheduler and the channel engines.
package jt053260_pkg;

   localparam int JT053260_NCH = 4;
   localparam int JT053260_AW  = 21;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/jt053260_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping modulo NCH.
module jt053260_rr_pick #(
   parameter int NCH = 4,
   parameter int PW  = 2
)(
   input  logic [NCH-1:0] i_req,
   input  logic [PW-1:0]  i_ptr,
   output logic           o_any,
   output logic [PW-1:0]  o_gnt
);

   logic [PW-1:0] w_idx;

   // Scan from farthest to nearest so the nearest requester after i_ptr is the last write
   always_comb begin
      o_any = |i_req;
      o_gnt = {PW{1'b0}};
      w_idx = {PW{1'b0}};
      for (int i = NCH; i >= 1; i--) begin
         w_idx = PW'((int'(i_ptr) + i) % NCH);
         if (i_req[w_idx]) begin
            o_gnt = w_idx;
         end
      end
   end

endmodule

// File: rtl/jt053260_rom_sched.sv
// Round-robin scheduler of the single K053260 sample-ROM port among its channels.
// Optional per-channel last-byte cache enabled by macro JT053260_ROMCACHE_EN.
module jt053260_rom_sched
   import jt053260_pkg::*;
#(
   parameter int NCH  = JT053260_NCH,
   parameter int AW   = JT053260_AW,
   parameter int TOUT = 255
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    req,
   input  logic [NCH*AW-1:0] ch_addr,
   output logic [NCH-1:0]    ack,
   output logic [7:0]        dout,
   output logic [AW-1:0]     rom_addr,
   output logic              rom_cs,
   input  logic              rom_ok,
   input  logic [7:0]        rom_data,
   output logic              busy,
   output logic              tout_err
);

   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = (TOUT > 1) ? $clog2(TOUT) : 1;

   state_t        r_state;
   state_t        w_next;
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] r_gnt;
   logic [PW-1:0] w_gnt;
   logic          w_any;
   logic          w_grant;
   logic          w_hit;
   logic          w_rd;
   logic          w_tout;
   logic [AW-1:0] w_sel_addr;
   logic [7:0]    w_hit_data;
   logic [AW-1:0] r_addr;
   logic          r_cs;
   logic          r_terr;
   logic [7:0]    r_dout;
   logic [CW-1:0] r_cnt;

   jt053260_rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_any (w_any),
      .o_gnt (w_gnt)
   );

   assign w_sel_addr = ch_addr[int'(w_gnt)*AW +: AW];

`ifdef JT053260_ROMCACHE_EN
   logic [NCH-1:0] r_cv;
   logic [AW-1:0]  r_caddr [NCH];
   logic [7:0]     r_cdata [NCH];

   assign w_hit      = r_cv[w_gnt] && (r_caddr[w_gnt] == w_sel_addr);
   assign w_hit_data = r_cdata[w_gnt];

   // Cache entry per channel: filled by a real fetch, dropped on timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cv <= {NCH{1'b0}};
      end else if (w_rd) begin
         r_cv[r_gnt]    <= 1'b1;
         r_caddr[r_gnt] <= r_addr;
         r_cdata[r_gnt] <= rom_data;
      end else if (w_tout) begin
         r_cv[r_gnt] <= 1'b0;
      end
   end
`else
   assign w_hit      = 1'b0;
   assign w_hit_data = 8'h00;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state; ISSUE always lasts one cycle because rom_ok may still refer to the old address
   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      w_rd    = 1'b0;
      w_tout  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_grant = 1'b1;
               w_next  = w_hit ? DONE : ISSUE;
            end else begin
               w_next = IDLE;
            end
         end
         ISSUE: w_next = WAIT;
         WAIT: begin
            if (rom_ok) begin
               w_rd   = 1'b1;
               w_next = DONE;
            end else if ((TOUT > 0) && (r_cnt == CW'(TOUT - 1))) begin
               w_tout = 1'b1;
               w_next = DONE;
            end else begin
               w_next = WAIT;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Datapath: grant latch, ROM bus, returned byte, timeout counter and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr  <= PW'(NCH - 1);
         r_gnt  <= {PW{1'b0}};
         r_addr <= {AW{1'b0}};
         r_cs   <= 1'b0;
         r_dout <= 8'h00;
         r_terr <= 1'b0;
         r_cnt  <= {CW{1'b0}};
      end else begin
         if (w_grant) begin
            r_gnt <= w_gnt;
            r_ptr <= w_gnt;
            if (w_hit) begin
               r_dout <= w_hit_data;
            end else begin
               r_addr <= w_sel_addr;
               r_cs   <= 1'b1;
            end
         end
         if (r_state == ISSUE) begin
            r_cnt <= {CW{1'b0}};
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_rd) begin
            r_dout <= rom_data;
            r_cs   <= 1'b0;
         end
         if (w_tout) begin
            r_dout <= 8'h00;
            r_cs   <= 1'b0;
            r_terr <= 1'b1;
         end
      end
   end

   // The ack is qualified by the live request so an abandoned fetch is dropped silently
   assign ack      = ((r_state == DONE) && req[r_gnt]) ? (NCH'(1) << r_gnt) : {NCH{1'b0}};
   assign dout     = r_dout;
   assign rom_addr = r_addr;
   assign rom_cs   = r_cs;
   assign busy     = (r_state != IDLE);
   assign tout_err = r_terr;

endmodule

// File: tb/tb_jt053260_rom_sched.sv
// Directed bench for jt053260_rom_sched (TOUT=8); the cache sequence runs when JT053260_ROMCACHE_EN is defined.
module tb_jt053260_rom_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [83:0] ch_addr;
   logic [3:0]  ack;
   logic [7:0]  dout;
   logic [20:0] rom_addr;
   logic        rom_cs;
   logic        rom_ok;
   logic [7:0]  rom_data;
   logic        busy;
   logic        tout_err;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0]  rq;
      logic [20:0] base;
      int          lat;
      logic [7:0]  data;
      logic [3:0]  exp_ack;
      logic [20:0] exp_addr;
   } vec_t;

   vec_t vt[10];

   jt053260_rom_sched #(.TOUT(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .ch_addr  (ch_addr),
      .ack      (ack),
      .dout     (dout),
      .rom_addr (rom_addr),
      .rom_cs   (rom_cs),
      .rom_ok   (rom_ok),
      .rom_data (rom_data),
      .busy     (busy),
      .tout_err (tout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [83:0] mk(input logic [20:0] b);
      return {b + 21'h300, b + 21'h200, b + 21'h100, b};
   endfunction

   initial begin
      // rr pointer starts at 3, so grants follow the scan from ch0
      vt[0] = '{4'b0001, 21'h00100, 2, 8'hA5, 4'b0001, 21'h00100};
      vt[1] = '{4'b1111, 21'h01000, 1, 8'h11, 4'b0010, 21'h01100};
      vt[2] = '{4'b1111, 21'h02000, 3, 8'h22, 4'b0100, 21'h02200};
      vt[3] = '{4'b1111, 21'h03000, 0, 8'h33, 4'b1000, 21'h03300};
      vt[4] = '{4'b1111, 21'h04000, 4, 8'h44, 4'b0001, 21'h04000};
      vt[5] = '{4'b1001, 21'h05000, 5, 8'h55, 4'b1000, 21'h05300};
      vt[6] = '{4'b1001, 21'h06000, 6, 8'h66, 4'b0001, 21'h06000};
      vt[7] = '{4'b0100, 21'h1FC00, 7, 8'hFF, 4'b0100, 21'h1FE00};
      vt[8] = '{4'b0110, 21'h07000, 0, 8'h3C, 4'b0010, 21'h07100};
      vt[9] = '{4'b1010, 21'h08000, 2, 8'hC3, 4'b1000, 21'h08300};

      rst = 1'b1; req = 4'b0000; ch_addr = 84'h0; rom_ok = 1'b0; rom_data = 8'h00;
      repeat (3) tick();
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_addr", 32'(rom_addr), 32'h0);
      chk("rst_cs", 32'(rom_cs), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_terr", 32'(tout_err), 32'h0);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 10; v++) begin
         ch_addr = mk(vt[v].base);
         req = vt[v].rq;
         tick();
         chk($sformatf("v%0d_cs", v), 32'(rom_cs), 32'h1);
         chk($sformatf("v%0d_addr", v), 32'(rom_addr), 32'(vt[v].exp_addr));
         tick();
         for (int k = 0; k < vt[v].lat; k++) tick();
         chk($sformatf("v%0d_noack", v), 32'(ack), 32'h0);
         rom_ok = 1'b1; rom_data = vt[v].data;
         tick();
         chk($sformatf("v%0d_ack", v), 32'(ack), 32'(vt[v].exp_ack));
         chk($sformatf("v%0d_dout", v), 32'(dout), 32'(vt[v].data));
         chk($sformatf("v%0d_csoff", v), 32'(rom_cs), 32'h0);
         rom_ok = 1'b0; rom_data = 8'h00;
         req = req & ~vt[v].exp_ack;
         tick();
         chk($sformatf("v%0d_idle", v), 32'(busy), 32'h0);
      end

      // Stale rom_ok held high: ISSUE must not sample it
      req = 4'b0000;
      ch_addr = mk(21'h09000); rom_ok = 1'b1; rom_data = 8'h77;
      req = 4'b0100;
      tick();
      chk("stale_cs", 32'(rom_cs), 32'h1);
      chk("stale_addr", 32'(rom_addr), 32'h09200);
      tick();
      chk("stale_noack", 32'(ack), 32'h0);
      chk("stale_hold", 32'(dout), 32'hC3);
      tick();
      chk("stale_ack", 32'(ack), 32'h4);
      chk("stale_dout", 32'(dout), 32'h77);
      rom_ok = 1'b0; req = 4'b0000;
      tick();
      chk("dout_hold", 32'(dout), 32'h77);

      // Request dropped mid-fetch: bus completes, no ack
      ch_addr = mk(21'h0A000); req = 4'b1000;
      tick();
      chk("drop_addr", 32'(rom_addr), 32'h0A300);
      req = 4'b0000;
      tick();
      chk("drop_cs", 32'(rom_cs), 32'h1);
      rom_ok = 1'b1; rom_data = 8'h99;
      tick();
      chk("drop_noack", 32'(ack), 32'h0);
      chk("drop_dout", 32'(dout), 32'h99);
      rom_ok = 1'b0;
      tick();
      chk("drop_idle", 32'(busy), 32'h0);

      // Timeout after 8 WAIT cycles
      ch_addr = mk(21'h0B000); req = 4'b0001;
      tick();
      tick();
      repeat (7) tick();
      chk("to_cs_still", 32'(rom_cs), 32'h1);
      chk("to_err_pre", 32'(tout_err), 32'h0);
      chk("to_noack", 32'(ack), 32'h0);
      tick();
      chk("to_ack", 32'(ack), 32'h1);
      chk("to_dout", 32'(dout), 32'h00);
      chk("to_err", 32'(tout_err), 32'h1);
      chk("to_cs", 32'(rom_cs), 32'h0);
      req = 4'b0000;
      tick();
      chk("to_sticky", 32'(tout_err), 32'h1);

      // req still high after its ack is a new request; address changes in the ack cycle
      ch_addr = mk(21'h0C000); req = 4'b0010;
      tick();
      chk("rr_addr1", 32'(rom_addr), 32'h0C100);
      tick();
      rom_ok = 1'b1; rom_data = 8'h5E;
      tick();
      chk("rr_ack1", 32'(ack), 32'h2);
      ch_addr = mk(21'h0D000); rom_ok = 1'b0;
      tick();
      tick();
      chk("rr_cs2", 32'(rom_cs), 32'h1);
      chk("rr_addr2", 32'(rom_addr), 32'h0D100);
      tick();
      rom_ok = 1'b1; rom_data = 8'hE5;
      tick();
      chk("rr_ack2", 32'(ack), 32'h2);
      chk("rr_dout2", 32'(dout), 32'hE5);
      req = 4'b0000; rom_ok = 1'b0;
      tick();

      // Reset during WAIT
      ch_addr = mk(21'h0E000); req = 4'b0100;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("mrst_cs", 32'(rom_cs), 32'h0);
      chk("mrst_busy", 32'(busy), 32'h0);
      chk("mrst_ack", 32'(ack), 32'h0);
      chk("mrst_terr", 32'(tout_err), 32'h0);
      rst = 1'b0; ch_addr = mk(21'h0F000); req = 4'b1100;
      tick();
      chk("mrst_ptr", 32'(rom_addr), 32'h0F200);
      tick();
      rom_ok = 1'b1; rom_data = 8'h12;
      tick();
      chk("mrst_ack2", 32'(ack), 32'h4);
      req = 4'b0000; rom_ok = 1'b0;
      tick();

`ifdef JT053260_ROMCACHE_EN
      // Second fetch of the same address by ch2 is served from the cache
      ch_addr = {21'h00000, 21'h1FFFF, 21'h00000, 21'h00000};
      req = 4'b0100;
      tick();
      chk("c_cs1", 32'(rom_cs), 32'h1);
      tick();
      rom_ok = 1'b1; rom_data = 8'h6B;
      tick();
      chk("c_ack1", 32'(ack), 32'h4);
      req = 4'b0000; rom_ok = 1'b0; rom_data = 8'h00;
      tick();
      req = 4'b0100;
      tick();
      chk("c_nocs", 32'(rom_cs), 32'h0);
      chk("c_ack2", 32'(ack), 32'h4);
      chk("c_dout2", 32'(dout), 32'h6B);
      req = 4'b0000;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
